// File: rtl/reg_file_wb_pkg.sv
// ============================================================================
// Module : rf_pkg
// Brief  : Shared sizing constants for the write-back register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;
    localparam int              DATA_W    = 16;
    localparam int              NUM_REGS  = 8;
    localparam int              REG_IDX_W = 3;
    localparam logic [2:0]      PC_IDX    = 3'd7;
    localparam logic [15:0]     RESET_PC  = 16'h0000;
endpackage

`default_nettype wire

// File: rtl/reg_file_wb_if.sv
// ============================================================================
// Module : reg_file_wb_if
// Brief  : Read, write-back and issue/scoreboard signals of the register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_wb_if;
    import rf_pkg::*;

    logic [REG_IDX_W-1:0] readAddr1;
    logic [REG_IDX_W-1:0] readAddr2;
    logic [DATA_W-1:0]    RFOut1;
    logic [DATA_W-1:0]    RFOut2;
    logic [DATA_W-1:0]    pcOut;
    logic                 regWrite;
    logic [REG_IDX_W-1:0] writeAddr;
    logic [DATA_W-1:0]    writeData;
    logic                 r7Write;
    logic [DATA_W-1:0]    writeR7Data;
    logic                 issueValid;
    logic [REG_IDX_W-1:0] issueDest;
    logic                 flush;
    logic                 busy1;
    logic                 busy2;
    logic [NUM_REGS-1:0]  busyMask;

    modport master (
        output readAddr1, readAddr2, regWrite, writeAddr, writeData,
               r7Write, writeR7Data, issueValid, issueDest, flush,
        input  RFOut1, RFOut2, pcOut, busy1, busy2, busyMask
    );

    modport slave (
        input  readAddr1, readAddr2, regWrite, writeAddr, writeData,
               r7Write, writeR7Data, issueValid, issueDest, flush,
        output RFOut1, RFOut2, pcOut, busy1, busy2, busyMask
    );
endinterface

`default_nettype wire

// File: rtl/reg_file_wb_scoreboard.sv
// ============================================================================
// Module : rf_scoreboard
// Brief  : One pending bit per register; issue sets, write-back clears.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 issueValid,
    input  wire logic [REG_IDX_W-1:0] issueDest,
    input  wire logic                 clrValid,
    input  wire logic [REG_IDX_W-1:0] clrIdx,
    input  wire logic                 flush,
    output logic      [NUM_REGS-1:0]  busyMask
);
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        // PC is never tracked here; its hazards are resolved by flushing.
        if (issueValid && issueDest != PC_IDX) set_vec[issueDest] = 1'b1;
        if (clrValid)                          clr_vec[clrIdx]    = 1'b1;
        // Set applied after clear so the newer producer stays pending.
        busy_next = flush ? '0 : ((busyMask & ~clr_vec) | set_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) busyMask <= '0;
        else       busyMask <= busy_next;
    end
endmodule

`default_nettype wire

// File: rtl/reg_file_wb.sv
// ============================================================================
// Module : reg_file_wb
// Brief  : 8x16 register file with dedicated PC write port, bypassed reads
//          and a pending-write scoreboard for RAW hazard detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_wb
    import rf_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = rf_pkg::RESET_PC,
    parameter int                BYPASS   = 1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    reg_file_wb_if.slave bus
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == NUM_REGS - 1) begin : g_pc
                always_ff @(posedge clk) begin
                    if (reset)
                        regs[gi] <= RESET_PC;
                    else if (bus.r7Write)
                        regs[gi] <= bus.writeR7Data;
                    else if (bus.regWrite && bus.writeAddr == PC_IDX)
                        regs[gi] <= bus.writeData;
                end
            end else begin : g_gpr
                always_ff @(posedge clk) begin
                    if (reset)
                        regs[gi] <= '0;
                    else if (bus.regWrite && bus.writeAddr == REG_IDX_W'(gi))
                        regs[gi] <= bus.writeData;
                end
            end
        end
    endgenerate

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [REG_IDX_W-1:0] addr,
        input logic [DATA_W-1:0]    stored,
        input logic                 rw,
        input logic [REG_IDX_W-1:0] wa,
        input logic [DATA_W-1:0]    wd,
        input logic                 r7w,
        input logic [DATA_W-1:0]    r7d
    );
        read_mux = stored;
        if (BYPASS != 0) begin
            if (addr == PC_IDX) begin
                if (r7w)                   read_mux = r7d;
                else if (rw && wa == addr) read_mux = wd;
            end else if (rw && wa == addr) begin
                read_mux = wd;
            end
        end
    endfunction

    logic [NUM_REGS-1:0] busy_q;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .issueValid(bus.issueValid),
        .issueDest (bus.issueDest),
        .clrValid  (bus.regWrite),
        .clrIdx    (bus.writeAddr),
        .flush     (bus.flush),
        .busyMask  (busy_q)
    );

    logic hit1;
    logic hit2;

    always_comb begin
        bus.RFOut1 = read_mux(bus.readAddr1, regs[bus.readAddr1], bus.regWrite,
                              bus.writeAddr, bus.writeData, bus.r7Write, bus.writeR7Data);
        bus.RFOut2 = read_mux(bus.readAddr2, regs[bus.readAddr2], bus.regWrite,
                              bus.writeAddr, bus.writeData, bus.r7Write, bus.writeR7Data);
        bus.pcOut  = regs[PC_IDX];

        // A completing write seen this cycle already resolves the hazard.
        hit1 = (BYPASS != 0) && bus.regWrite && (bus.writeAddr == bus.readAddr1);
        hit2 = (BYPASS != 0) && bus.regWrite && (bus.writeAddr == bus.readAddr2);
        bus.busy1 = (bus.readAddr1 != PC_IDX) && busy_q[bus.readAddr1] && !hit1;
        bus.busy2 = (bus.readAddr2 != PC_IDX) && busy_q[bus.readAddr2] && !hit2;
        bus.busyMask = busy_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_reg_file_wb.sv
// ============================================================================
// Module : tb_reg_file_wb
// Brief  : Directed + random stimulus against a behavioural register model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_wb_if rif();

    reg_file_wb #(.RESET_PC(16'h0040), .BYPASS(1)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (rif.slave)
    );

    typedef struct {
        logic [15:0] rf1;
        logic [15:0] rf2;
        logic [15:0] pc;
        logic        b1;
        logic        b2;
        logic [7:0]  mask;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] m_regs [8];
    bit          m_busy [8];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd7) begin
            if (rif.r7Write)                                return rif.writeR7Data;
            if (rif.regWrite && rif.writeAddr == 3'd7)      return rif.writeData;
            return m_regs[7];
        end
        if (rif.regWrite && rif.writeAddr == a) return rif.writeData;
        return m_regs[a];
    endfunction

    function automatic logic m_busy_rd(input logic [2:0] a);
        if (a == 3'd7) return 1'b0;
        return m_busy[a] && !(rif.regWrite && rif.writeAddr == a);
    endfunction

    // Push expected outputs for the current inputs, then advance the model one edge.
    task automatic step(input bit check);
        exp_t e;
        if (check) begin
            e.rf1 = m_read(rif.readAddr1);
            e.rf2 = m_read(rif.readAddr2);
            e.pc  = m_regs[7];
            e.b1  = m_busy_rd(rif.readAddr1);
            e.b2  = m_busy_rd(rif.readAddr2);
            for (int i = 0; i < 8; i++) e.mask[i] = m_busy[i];
            expq.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 7; i++) m_regs[i] = 16'h0;
            m_regs[7] = 16'h0040;
            for (int i = 0; i < 8; i++) m_busy[i] = 0;
        end else begin
            if (rif.regWrite) m_regs[rif.writeAddr] = rif.writeData;
            if (rif.r7Write)  m_regs[7] = rif.writeR7Data;
            if (rif.flush) begin
                for (int i = 0; i < 8; i++) m_busy[i] = 0;
            end else begin
                if (rif.regWrite) m_busy[rif.writeAddr] = 0;
                if (rif.issueValid && rif.issueDest != 3'd7) m_busy[rif.issueDest] = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        rif.regWrite = 0; rif.writeAddr = 0; rif.writeData = 0;
        rif.r7Write = 0; rif.writeR7Data = 0;
        rif.issueValid = 0; rif.issueDest = 0; rif.flush = 0;
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("RFOut1",   rif.RFOut1,          e.rf1);
            chk("RFOut2",   rif.RFOut2,          e.rf2);
            chk("pcOut",    rif.pcOut,           e.pc);
            chk("busy1",    {15'h0, rif.busy1},  {15'h0, e.b1});
            chk("busy2",    {15'h0, rif.busy2},  {15'h0, e.b2});
            chk("busyMask", {8'h0, rif.busyMask}, {8'h0, e.mask});
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin m_regs[i] = 16'h0; m_busy[i] = 0; end
        idle();
        rst = 1'b1;
        rif.readAddr1 = 3'd3; rif.readAddr2 = 3'd7;
        @(posedge clk); #1;
        step(0);                      // state unknown before the first reset edge
        idle();
        step(1);                      // reset values: pc=0040, R3=0, mask=0

        // write then read, bypass and registered
        rif.regWrite = 1; rif.writeAddr = 2; rif.writeData = 16'hBEEF; rif.readAddr1 = 2;
        step(1);
        idle(); step(1);

        // R7 port beats general port
        rif.regWrite = 1; rif.writeAddr = 7; rif.writeData = 16'h1111;
        rif.r7Write = 1; rif.writeR7Data = 16'h2222; rif.readAddr2 = 7;
        step(1);
        idle(); step(1);

        // scoreboard set, bypass-clear, registered clear
        rif.issueValid = 1; rif.issueDest = 4; rif.readAddr1 = 4;
        step(1);
        idle(); step(1);
        rif.regWrite = 1; rif.writeAddr = 4; rif.writeData = 16'h0444;
        step(1);
        idle(); step(1);

        // set/clear collision on R5
        rif.issueValid = 1; rif.issueDest = 5; rif.readAddr2 = 5;
        step(1);
        rif.issueValid = 1; rif.issueDest = 5;
        rif.regWrite = 1; rif.writeAddr = 5; rif.writeData = 16'h0555;
        step(1);
        idle(); step(1);
        rif.regWrite = 1; rif.writeAddr = 5; rif.writeData = 16'h0556;
        step(1);

        // busyMask 0E then flush with a concurrent issue
        for (int d = 1; d <= 3; d++) begin
            idle(); rif.issueValid = 1; rif.issueDest = 3'(d); step(1);
        end
        idle(); step(1);
        rif.flush = 1; rif.issueValid = 1; rif.issueDest = 1;
        step(1);
        idle(); step(1);

        // reset during a write to R2
        rst = 1; rif.regWrite = 1; rif.writeAddr = 2; rif.writeData = 16'h7777;
        rif.issueValid = 1; rif.issueDest = 6; rif.readAddr1 = 2;
        step(1);
        idle(); step(1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 59) == 0);
            rif.regWrite   = $urandom_range(0, 1);
            rif.writeAddr  = 3'($urandom_range(0, 7));
            rif.writeData  = 16'($urandom);
            rif.r7Write    = ($urandom_range(0, 5) == 0);
            rif.writeR7Data = 16'($urandom);
            rif.issueValid = $urandom_range(0, 1);
            rif.issueDest  = 3'($urandom_range(0, 7));
            rif.flush      = ($urandom_range(0, 19) == 0);
            rif.readAddr1  = ($urandom_range(0, 3) == 0) ? rif.writeAddr : 3'($urandom_range(0, 7));
            rif.readAddr2  = ($urandom_range(0, 3) == 0) ? rif.issueDest : 3'($urandom_range(0, 7));
            step(1);
        end
        idle();

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
        if (expq.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, required 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
